// File: rtl/channel_display_scheduler_if.sv
// Channel-producer handshake bundle: per-channel request, packed samples and capture acknowledge.
interface channel_display_scheduler_if #(
  parameter int NCH = 13,
  parameter int DW  = 12
);
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    ack;

  modport master (output req, output data_in, input ack);
  modport slave  (input req, input data_in, output ack);
endinterface

// File: rtl/channel_display_scheduler.sv
// Round-robin capture of channel samples into a staging bank, published to the
// display bank during vertical blanking so each frame sees a consistent set.
module channel_display_scheduler #(
  parameter int NCH = 13,
  parameter int DW  = 12,
  parameter int IW  = 4
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     vblnk_in,
  input  logic                     freeze,
  channel_display_scheduler_if.slave chan,
  output logic [NCH*DW-1:0]        disp_data,
  output logic [NCH-1:0]           disp_valid,
  output logic                     frame_start,
  output logic                     busy,
  output logic [7:0]               frame_cnt
);

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   stage [NCH];
  logic [NCH-1:0]  dirty;
  logic [NCH-1:0]  eligible;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant_idx;
  logic            grant_valid;
  logic [IW-1:0]   idx;
  logic            vb_d;
  logic            rise;
  logic            copy_hit;

  assign eligible = chan.req & ~chan.ack;
  assign rise     = vblnk_in & ~vb_d;
  assign copy_hit = (state == COPY) && vblnk_in && dirty[idx];

  // First eligible channel at or after the pointer, wrapping past NCH-1.
  always_comb begin
    int unsigned   j;
    logic [IW-1:0] jj;
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    jj          = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      j = int'(ptr) + i;
      if (j >= NCH) j = j - NCH;
      jj = IW'(j);
      if (!grant_valid && eligible[jj]) begin
        grant_valid = 1'b1;
        grant_idx   = jj;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      chan.ack <= '0;
      ptr      <= '0;
      vb_d     <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) stage[k] <= '0;
    end else begin
      chan.ack <= '0;
      vb_d     <= vblnk_in;
      if (grant_valid) begin
        chan.ack[grant_idx] <= 1'b1;
        stage[grant_idx]    <= chan.data_in[grant_idx*DW +: DW];
        ptr                 <= (grant_idx == IW'(NCH-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // A fresh capture outranks the publish clear so the new sample goes out next frame.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      dirty <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (grant_valid && grant_idx == IW'(k))
          dirty[k] <= 1'b1;
        else if (copy_hit && idx == IW'(k))
          dirty[k] <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise && !freeze) state_next = COPY;
      COPY:    if (!vblnk_in || idx == IW'(NCH-1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == COPY);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      disp_data   <= '0;
      disp_valid  <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= (state == IDLE) && rise && !freeze;
      if (state == COPY) idx <= idx + 1'b1;
      else               idx <= '0;
      if (copy_hit) begin
        disp_data[idx*DW +: DW] <= stage[idx];
        disp_valid[idx]         <= 1'b1;
      end
      if (state == DONE) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule
